serial_add_seq: RTL and testbench

SERIAL_ADD_SEQ -- requirements
Module: serial_add_seq

---
 rtl/serial_add_seq.sv | 118 +++++++++++
 tb/tb_serial_add_seq.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_seq.sv
// rtl/serial_add_seq.sv - bit-serial adder, LSB first, with IDLE/SHIFT/DONE sequencer
// Optional subtraction is enabled by defining SERIAL_ADD_SUB_EN.
module serial_add_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             shift_en,
  output logic             s_bit,
  output logic             oe,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh, res;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             last;
  logic             sum_bit;
  logic             carry_nxt;
  logic [WIDTH-1:0] b_load;
  logic             c_load;

`ifdef SERIAL_ADD_SUB_EN
  // Two's-complement subtract: invert B and inject a carry-in of one.
  assign b_load = sub ? ~b : b;
  assign c_load = sub;
`else
  logic unused_sub;
  assign unused_sub = sub;
  assign b_load     = b;
  assign c_load     = 1'b0;
`endif

  assign last      = (cnt == CW'(WIDTH - 1));
  assign sum_bit   = a_sh[0] ^ b_sh[0] ^ carry;
  assign carry_nxt = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    shift_en  = 1'b0;
    s_bit     = 1'b0;
    done      = 1'b0;
    oe        = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = SHIFT;
      end
      SHIFT: begin
        busy     = 1'b1;
        shift_en = 1'b1;
        s_bit    = sum_bit;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        oe        = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh  <= '0;
      b_sh  <= '0;
      res   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b_load;
            carry <= c_load;
            cnt   <= '0;
          end
        end
        SHIFT: begin
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          carry <= carry_nxt;
          res   <= {sum_bit, res[WIDTH-1:1]};
          cnt   <= cnt + CW'(1);
          // Publish the result on the edge that enters DONE.
          if (last) begin
            sum  <= {sum_bit, res[WIDTH-1:1]};
            cout <= carry_nxt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_seq.sv
// tb/tb_serial_add_seq.sv - self-checking bench for serial_add_seq with arithmetic reference model
module tb_serial_add_seq;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst, start, sub;
  logic [W-1:0] a, b;
  logic         busy, shift_en, s_bit, oe, done, cout;
  logic [W-1:0] sum;

  serial_add_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b),
    .busy(busy), .shift_en(shift_en), .s_bit(s_bit), .oe(oe), .done(done),
    .sum(sum), .cout(cout)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Reference model: phase 0 idle, 1..W shift bit phase-1, W+1 done.
  int           m_phase = 0;
  logic [W:0]   m_full  = '0;
  logic [W-1:0] m_sum   = '0;
  logic         m_cout  = 1'b0;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_phase = 0;
      m_sum   = '0;
      m_cout  = 1'b0;
    end else if (m_phase == 0) begin
      if (start) begin
        logic [W-1:0] bb;
        logic         cin;
`ifdef SERIAL_ADD_SUB_EN
        bb  = sub ? ~b : b;
        cin = sub;
`else
        bb  = b;
        cin = 1'b0;
`endif
        m_full  = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, cin};
        m_phase = 1;
      end
    end else if (m_phase == W + 1) begin
      m_phase = 0;
    end else begin
      m_phase++;
      if (m_phase == W + 1) begin
        m_sum  = m_full[W-1:0];
        m_cout = m_full[W];
      end
    end
  end

  // Per-cycle compare plus capture of serial bits and done pulses.
  logic [W-1:0] seq     = '0;
  int           done_cnt = 0;
  int           se_cnt   = 0;

  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
    if (shift_en === 1'b1) begin
      se_cnt++;
      seq = {s_bit, seq[W-1:1]};
    end
    if (chk_en) begin
      logic e_shift;
      e_shift = (m_phase >= 1) && (m_phase <= W);
      chk("busy", busy, m_phase != 0);
      chk("shift_en", shift_en, e_shift);
      chk("s_bit", s_bit, e_shift ? m_full[m_phase-1] : 1'b0);
      chk("done", done, m_phase == W + 1);
      chk("oe", oe, m_phase == W + 1);
      chk("sum", sum, m_sum);
      chk("cout", cout, m_cout);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string name, output int n);
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    if (done !== 1'b1) chk({name, "_timeout"}, 0, 1);
  endtask

  // Drive one start pulse, return edges from acceptance until done is visible.
  task automatic run_op(input string name, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic sv, output int n);
    start = 1'b1; a = av; b = bv; sub = sv;
    step();
    start = 1'b0;
    wait_done(name, n);
  endtask

  initial begin
    int n, d0, d1, d2, base_d, base_se;
    rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    step(); step();
    rst = 1'b0;
    chk_en = 1'b1;
    chk("rst_busy", busy, 0);
    chk("rst_shift_en", shift_en, 0);
    chk("rst_s_bit", s_bit, 0);
    chk("rst_done", {oe, done}, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);

    // 3 + 5: serial bits LSB first spell 0x08, done in cycle W+1 after start cycle
    base_se = se_cnt;
    run_op("add35", 8'h03, 8'h05, 1'b0, n);
    chk("add35_done_cycle", n + 1, 9);
    chk("add35_shift_cycles", se_cnt - base_se, 8);
    chk("add35_seq", seq, 8'h08);
    chk("add35_sum", sum, 8'h08);
    chk("add35_cout", cout, 0);
    step();
    chk("add35_done_pulse", {done, oe}, 0);

    run_op("addff01", 8'hFF, 8'h01, 1'b0, n);
    chk("addff01_sum", sum, 8'h00);
    chk("addff01_cout", cout, 1);
    step();
    chk("addff01_pulse", {done, oe}, 0);

    // start during SHIFT must be ignored
    base_d = done_cnt;
    start = 1'b1; a = 8'h11; b = 8'h22; sub = 1'b0;
    step();
    start = 1'b0;
    step(); step();
    start = 1'b1; a = 8'h77; b = 8'h77;
    step();
    start = 1'b0;
    wait_done("ignore", n);
    chk("ignore_sum", sum, 8'h33);
    repeat (12) step();
    chk("ignore_one_done", done_cnt - base_d, 1);

    // reset during the 4th SHIFT cycle aborts with no done
    base_d = done_cnt;
    start = 1'b1; a = 8'h5A; b = 8'h21;
    step();
    start = 1'b0;
    step(); step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_outputs", {busy, shift_en, s_bit, oe, done, cout}, 0);
    chk("abort_sum", sum, 0);
    repeat (12) step();
    chk("abort_no_done", done_cnt - base_d, 0);
    run_op("after_abort", 8'h40, 8'h02, 1'b0, n);
    chk("after_abort_sum", sum, 8'h42);

    // start held: done every W+2 cycles
    start = 1'b1; a = 8'h10; b = 8'h20;
    step();
    wait_done("held0", n); d0 = cyc; chk("held0_sum", sum, 8'h30);
    step();
    wait_done("held1", n); d1 = cyc; chk("held1_sum", sum, 8'h30);
    step();
    wait_done("held2", n); d2 = cyc; chk("held2_sum", sum, 8'h30);
    chk("held_period1", d1 - d0, W + 2);
    chk("held_period2", d2 - d1, W + 2);
    start = 1'b0;
    repeat (12) step();

`ifdef SERIAL_ADD_SUB_EN
    run_op("sub53", 8'h05, 8'h03, 1'b1, n);
    chk("sub53_sum", sum, 8'h02);
    chk("sub53_cout", cout, 1);
    run_op("sub35", 8'h03, 8'h05, 1'b1, n);
    chk("sub35_sum", sum, 8'hFE);
    chk("sub35_cout", cout, 0);
`else
    run_op("nosub", 8'h05, 8'h03, 1'b1, n);
    chk("nosub_sum", sum, 8'h08);
    chk("nosub_cout", cout, 0);
`endif
    sub = 1'b0;
    step();

    // random traffic, model checked every cycle
    for (int i = 0; i < 3000; i++) begin
      start = ($urandom_range(0, 2) == 0);
      sub   = $urandom_range(0, 1);
      a     = W'($urandom);
      b     = W'($urandom);
      rst   = ($urandom_range(0, 150) == 0);
      step();
    end
    rst = 1'b0; start = 1'b0;
    repeat (12) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
